axi2iob: RTL and testbench

- AXI4-full slave to IOb-native master bridge; the reverse direction of iob2axi.
- Lets AXI masters (DMA, interconnect, iob2axi itself in loopback benches) access IOb-native peripherals and memories.
- Converts each INCR/FIXED burst into one IOb access per beat.
- One AXI transaction in flight at a time; write and read bursts are serialised by an arbiter.

---
 rtl/axi2iob_pkg.sv | 29 ++
 rtl/axi2iob_if.sv | 90 +++++++++
 rtl/axi2iob_addr_gen.sv | 60 ++++++
 rtl/axi2iob.sv | 193 +++++++++++++++++++
 tb/tb_axi2iob.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi2iob_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi2iob_pkg
//  Purpose  : Shared types and constants for the AXI4 slave to IOb-native
//             master bridge (FSM state encoding, AXI burst and resp codes).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package axi2iob_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_DATA = 3'd1,
    W_IOB  = 3'd2,
    W_RESP = 3'd3,
    R_IOB  = 3'd4,
    R_WAIT = 3'd5,
    R_DATA = 3'd6
  } state_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi2iob_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi2iob_if
//  Purpose  : Bundles the five AXI4 channels and the IOb-native master port
//             of the bridge.
//  Modports : slave  - the bridge: AXI slave side plus IOb master side
//             master - the environment: AXI master plus IOb memory
//  Revision : 1.0 - initial release
// ============================================================================
interface axi2iob_if #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int AXI_ID_W  = 1,
  parameter int AXI_LEN_W = 8
);
  // AW
  logic [AXI_ID_W-1:0]  axi_awid_i;
  logic [ADDR_W-1:0]    axi_awaddr_i;
  logic [AXI_LEN_W-1:0] axi_awlen_i;
  logic [2:0]           axi_awsize_i;
  logic [1:0]           axi_awburst_i;
  logic                 axi_awvalid_i;
  logic                 axi_awready_o;
  // W
  logic [DATA_W-1:0]    axi_wdata_i;
  logic [DATA_W/8-1:0]  axi_wstrb_i;
  logic                 axi_wlast_i;
  logic                 axi_wvalid_i;
  logic                 axi_wready_o;
  // B
  logic [AXI_ID_W-1:0]  axi_bid_o;
  logic [1:0]           axi_bresp_o;
  logic                 axi_bvalid_o;
  logic                 axi_bready_i;
  // AR
  logic [AXI_ID_W-1:0]  axi_arid_i;
  logic [ADDR_W-1:0]    axi_araddr_i;
  logic [AXI_LEN_W-1:0] axi_arlen_i;
  logic [2:0]           axi_arsize_i;
  logic [1:0]           axi_arburst_i;
  logic                 axi_arvalid_i;
  logic                 axi_arready_o;
  // R
  logic [AXI_ID_W-1:0]  axi_rid_o;
  logic [DATA_W-1:0]    axi_rdata_o;
  logic [1:0]           axi_rresp_o;
  logic                 axi_rlast_o;
  logic                 axi_rvalid_o;
  logic                 axi_rready_i;
  // IOb master
  logic                 iob_valid_o;
  logic [ADDR_W-1:0]    iob_addr_o;
  logic [DATA_W-1:0]    iob_wdata_o;
  logic [DATA_W/8-1:0]  iob_wstrb_o;
  logic                 iob_rvalid_i;
  logic [DATA_W-1:0]    iob_rdata_i;
  logic                 iob_ready_i;

  modport slave (
    input  axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i, axi_awvalid_i,
    output axi_awready_o,
    input  axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
    output axi_wready_o,
    output axi_bid_o, axi_bresp_o, axi_bvalid_o,
    input  axi_bready_i,
    input  axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i, axi_arvalid_i,
    output axi_arready_o,
    output axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
    input  axi_rready_i,
    output iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    input  iob_rvalid_i, iob_rdata_i, iob_ready_i
  );

  modport master (
    output axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i, axi_awvalid_i,
    input  axi_awready_o,
    output axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i,
    input  axi_wready_o,
    input  axi_bid_o, axi_bresp_o, axi_bvalid_o,
    output axi_bready_i,
    output axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i, axi_arvalid_i,
    input  axi_arready_o,
    input  axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o,
    output axi_rready_i,
    input  iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    output iob_rvalid_i, iob_rdata_i, iob_ready_i
  );

endinterface
`default_nettype wire

// File: rtl/axi2iob_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : axi2iob_addr_gen
//  Purpose  : Burst address generator. Latches start address, size and burst
//             type at the address handshake, steps once per beat, and flags
//             bursts the bridge cannot serve (WRAP, reserved type, oversize).
//  Ports    : clk, arst_n          - clock, async active-low reset
//             load                 - capture start_addr/size/burst
//             next                 - advance to the next beat address
//             start_addr/size/burst- AXI address-phase fields
//             addr                 - current beat address
//             err                  - burst is unsupported
//  Revision : 1.0 - initial release
// ============================================================================
module axi2iob_addr_gen
  import axi2iob_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              load,
  input  logic              next,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] addr,
  output logic              err
);

  localparam int SIZE_MAX = $clog2(DATA_W / 8);

  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              bad;
  logic [ADDR_W-1:0] step;

  assign bad  = (burst == AXI_BURST_WRAP) || (burst == 2'b11) || (size > 3'(SIZE_MAX));
  assign step = ADDR_W'(1) << size_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr    <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err     <= 1'b0;
    end else if (load) begin
      addr    <= start_addr;
      size_q  <= size;
      burst_q <= burst;
      err     <= bad;
    end else if (next && (burst_q == AXI_BURST_INCR)) begin
      // Natural modulo-2^ADDR_W wrap; no 4 KiB boundary handling.
      addr <= addr + step;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi2iob.sv
`default_nettype none
// ============================================================================
//  Module   : axi2iob
//  Purpose  : AXI4-full slave to IOb-native master bridge. One AXI burst in
//             flight; each beat becomes one IOb access. Write and read bursts
//             are arbitrated round-robin at the address phase.
//  Ports    : clk_i     - clock
//             arst_n_i  - asynchronous active-low reset
//             bus       - AXI AW/W/B/AR/R slave channels and IOb master port
//  Params   : ADDR_W, DATA_W (32 or 64), AXI_ID_W, AXI_LEN_W
//  Revision : 1.0 - initial release
// ============================================================================
module axi2iob
  import axi2iob_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int AXI_ID_W  = 1,
  parameter int AXI_LEN_W = 8
) (
  input logic      clk_i,
  input logic      arst_n_i,
  axi2iob_if.slave bus
);

  state_t               state, state_nxt;
  logic [AXI_ID_W-1:0]  id;
  logic [AXI_LEN_W-1:0] len, cnt;
  logic [DATA_W-1:0]    wdata, rdata;
  logic [DATA_W/8-1:0]  wstrb;
  logic                 wlast_err;
  logic                 last_wr;     // 1: write was served last, 0: read
  logic                 err;
  logic [ADDR_W-1:0]    addr;

  logic awready, arready, wready, bvalid, rvalid, iob_valid;
  logic step, rcap, last_beat, w_hs;

  assign last_beat = (cnt == len);
  assign w_hs      = wready && bus.axi_wvalid_i;

  axi2iob_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_addr_gen (
    .clk        (clk_i),
    .arst_n     (arst_n_i),
    .load       (awready || arready),
    .next       (step),
    .start_addr (awready ? bus.axi_awaddr_i  : bus.axi_araddr_i),
    .size       (awready ? bus.axi_awsize_i  : bus.axi_arsize_i),
    .burst      (awready ? bus.axi_awburst_i : bus.axi_arburst_i),
    .addr       (addr),
    .err        (err)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    arready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    iob_valid = 1'b0;
    step      = 1'b0;
    rcap      = 1'b0;
    case (state)
      IDLE: begin
        // Ready is raised only towards the channel that wins arbitration.
        if (bus.axi_awvalid_i && (!bus.axi_arvalid_i || !last_wr)) begin
          awready   = 1'b1;
          state_nxt = W_DATA;
        end else if (bus.axi_arvalid_i) begin
          arready   = 1'b1;
          state_nxt = R_IOB;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (bus.axi_wvalid_i) begin
          if (!err)           state_nxt = W_IOB;
          else if (last_beat) state_nxt = W_RESP;
          else                step      = 1'b1;  // drop the beat, stay here
        end
      end
      W_IOB: begin
        iob_valid = 1'b1;
        if (bus.iob_ready_i) begin
          if (last_beat) state_nxt = W_RESP;
          else begin
            step      = 1'b1;
            state_nxt = W_DATA;
          end
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bus.axi_bready_i) state_nxt = IDLE;
      end
      R_IOB: begin
        if (err) begin
          rcap      = 1'b1;  // loads zero data, no IOb access
          state_nxt = R_DATA;
        end else begin
          iob_valid = 1'b1;
          if (bus.iob_ready_i) begin
            if (bus.iob_rvalid_i) begin
              rcap      = 1'b1;
              state_nxt = R_DATA;
            end else begin
              state_nxt = R_WAIT;
            end
          end
        end
      end
      R_WAIT: begin
        if (bus.iob_rvalid_i) begin
          rcap      = 1'b1;
          state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (bus.axi_rready_i) begin
          if (last_beat) state_nxt = IDLE;
          else begin
            step      = 1'b1;
            state_nxt = R_IOB;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      id        <= '0;
      len       <= '0;
      cnt       <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      rdata     <= '0;
      wlast_err <= 1'b0;
      last_wr   <= 1'b0;
    end else begin
      if (awready) begin
        id        <= bus.axi_awid_i;
        len       <= bus.axi_awlen_i;
        cnt       <= '0;
        wlast_err <= 1'b0;
        last_wr   <= 1'b1;
      end else if (arready) begin
        id        <= bus.axi_arid_i;
        len       <= bus.axi_arlen_i;
        cnt       <= '0;
        wlast_err <= 1'b0;
        last_wr   <= 1'b0;
      end
      if (w_hs) begin
        wdata <= bus.axi_wdata_i;
        wstrb <= bus.axi_wstrb_i;
        // The burst length is authoritative; a misplaced wlast only taints B.
        if (bus.axi_wlast_i != last_beat) wlast_err <= 1'b1;
      end
      if (rcap) rdata <= err ? '0 : bus.iob_rdata_i;
      if (step) cnt <= cnt + 1'b1;
    end
  end

  assign bus.axi_awready_o = awready;
  assign bus.axi_arready_o = arready;
  assign bus.axi_wready_o  = wready;
  assign bus.axi_bvalid_o  = bvalid;
  assign bus.axi_bid_o     = id;
  assign bus.axi_bresp_o   = (err || wlast_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign bus.axi_rvalid_o  = rvalid;
  assign bus.axi_rid_o     = id;
  assign bus.axi_rdata_o   = rdata;
  assign bus.axi_rresp_o   = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign bus.axi_rlast_o   = rvalid && last_beat;
  assign bus.iob_valid_o   = iob_valid;
  assign bus.iob_addr_o    = addr;
  assign bus.iob_wdata_o   = wdata;
  assign bus.iob_wstrb_o   = (state == W_IOB) ? wstrb : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi2iob.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi2iob
//  Purpose  : Directed self-checking bench for axi2iob with a small IOb
//             memory model (programmable ready delay, 1-cycle read latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi2iob;

  localparam int TMO = 300;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  axi2iob_if #(.ADDR_W(24), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) bus ();

  axi2iob #(.ADDR_W(24), .DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- IOb memory model ----------------
  logic [31:0] mem [0:255];
  logic [31:0] log_addr [0:127];
  logic [31:0] log_data [0:127];
  logic        log_wr   [0:127];
  int  n_acc = 0, vcycles = 0, wait_cnt = 0, ready_delay = 0;
  bit  hold_rvalid = 0, rd_pend = 0;
  logic [7:0] rd_idx;

  always @(negedge clk) begin
    bus.iob_ready_i  = 1'b0;
    bus.iob_rvalid_i = 1'b0;
    if (rd_pend) begin
      bus.iob_rvalid_i = 1'b1;
      bus.iob_rdata_i  = mem[rd_idx];
      rd_pend = 0;
    end
    if (bus.iob_valid_o) begin
      vcycles++;
      if (wait_cnt >= ready_delay) begin
        bus.iob_ready_i = 1'b1;
        wait_cnt = 0;
        if (n_acc < 128) begin
          log_addr[n_acc] = 32'(bus.iob_addr_o);
          log_data[n_acc] = bus.iob_wdata_o;
          log_wr[n_acc]   = (bus.iob_wstrb_o != 4'h0);
        end
        n_acc++;
        if (bus.iob_wstrb_o == 4'h0) begin
          if (!hold_rvalid) begin
            rd_pend = 1;
            rd_idx  = bus.iob_addr_o[9:2];
          end
        end else begin
          for (int b = 0; b < 4; b++)
            if (bus.iob_wstrb_o[b])
              mem[bus.iob_addr_o[9:2]][8*b +: 8] = bus.iob_wdata_o[8*b +: 8];
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Address-handshake order: 1 = write, 2 = read
  int hs_log [0:15];
  int hs_n = 0;
  always @(negedge clk) begin
    if (bus.axi_awvalid_i && bus.axi_awready_o && hs_n < 16) begin hs_log[hs_n] = 1; hs_n++; end
    if (bus.axi_arvalid_i && bus.axi_arready_o && hs_n < 16) begin hs_log[hs_n] = 2; hs_n++; end
  end

  // ---------------- AXI master tasks ----------------
  task automatic aw_send(input logic id, input logic [23:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int t = 0;
    bus.axi_awid_i = id; bus.axi_awaddr_i = addr; bus.axi_awlen_i = len;
    bus.axi_awburst_i = burst; bus.axi_awsize_i = size; bus.axi_awvalid_i = 1'b1;
    @(negedge clk);
    while (!bus.axi_awready_o && t < TMO) begin @(negedge clk); t++; end
    check_eq("aw_ready", 64'(bus.axi_awready_o), 64'd1);
    @(posedge clk); #1;
    bus.axi_awvalid_i = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [23:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int t = 0;
    bus.axi_arid_i = id; bus.axi_araddr_i = addr; bus.axi_arlen_i = len;
    bus.axi_arburst_i = burst; bus.axi_arsize_i = size; bus.axi_arvalid_i = 1'b1;
    @(negedge clk);
    while (!bus.axi_arready_o && t < TMO) begin @(negedge clk); t++; end
    check_eq("ar_ready", 64'(bus.axi_arready_o), 64'd1);
    @(posedge clk); #1;
    bus.axi_arvalid_i = 1'b0;
  endtask

  task automatic write_burst(input logic id, input logic [23:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input logic [31:0] base, input bit bad_wlast, input logic [1:0] resp);
    int t;
    aw_send(id, addr, len, burst, size);
    for (int i = 0; i <= int'(len); i++) begin
      bus.axi_wdata_i  = base + 32'(i);
      bus.axi_wstrb_i  = 4'hf;
      bus.axi_wlast_i  = bad_wlast ? (i == 0) : (i == int'(len));
      bus.axi_wvalid_i = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.axi_wready_o && t < TMO) begin @(negedge clk); t++; end
      check_eq("w_ready", 64'(bus.axi_wready_o), 64'd1);
      @(posedge clk); #1;
      bus.axi_wvalid_i = 1'b0;
      bus.axi_wlast_i  = 1'b0;
    end
    bus.axi_bready_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bus.axi_bvalid_o && t < TMO) begin @(negedge clk); t++; end
    check_eq("b_valid", 64'(bus.axi_bvalid_o), 64'd1);
    check_eq("b_resp",  64'(bus.axi_bresp_o),  64'(resp));
    check_eq("b_id",    64'(bus.axi_bid_o),    64'(id));
    @(posedge clk); #1;
    bus.axi_bready_i = 1'b0;
  endtask

  task automatic read_burst(input logic id, input logic [23:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [31:0] base, input logic [31:0] dstep,
                            input logic [1:0] resp, input bit stall);
    int t;
    logic [31:0] exp;
    ar_send(id, addr, len, burst, size);
    for (int i = 0; i <= int'(len); i++) begin
      exp = base + dstep * 32'(i);
      bus.axi_rready_i = !stall || (i % 2 == 1);
      t = 0;
      @(negedge clk);
      while (!bus.axi_rvalid_o && t < TMO) begin @(negedge clk); t++; end
      check_eq("r_valid", 64'(bus.axi_rvalid_o), 64'd1);
      if (!bus.axi_rready_i) begin
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check_eq("r_hold_valid", 64'(bus.axi_rvalid_o), 64'd1);
          check_eq("r_hold_data",  64'(bus.axi_rdata_o),  64'(exp));
          check_eq("r_hold_last",  64'(bus.axi_rlast_o),  64'(i == int'(len)));
        end
        bus.axi_rready_i = 1'b1;
      end
      check_eq("r_data", 64'(bus.axi_rdata_o), 64'(exp));
      check_eq("r_resp", 64'(bus.axi_rresp_o), 64'(resp));
      check_eq("r_last", 64'(bus.axi_rlast_o), 64'(i == int'(len)));
      check_eq("r_id",   64'(bus.axi_rid_o),   64'(id));
      @(posedge clk); #1;
      bus.axi_rready_i = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  int b0, v0, t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
    $fatal(1);
  end

  initial begin
    bus.axi_awid_i = '0; bus.axi_awaddr_i = '0; bus.axi_awlen_i = '0; bus.axi_awsize_i = '0;
    bus.axi_awburst_i = '0; bus.axi_awvalid_i = 1'b0;
    bus.axi_wdata_i = '0; bus.axi_wstrb_i = '0; bus.axi_wlast_i = 1'b0; bus.axi_wvalid_i = 1'b0;
    bus.axi_bready_i = 1'b0;
    bus.axi_arid_i = '0; bus.axi_araddr_i = '0; bus.axi_arlen_i = '0; bus.axi_arsize_i = '0;
    bus.axi_arburst_i = '0; bus.axi_arvalid_i = 1'b0; bus.axi_rready_i = 1'b0;
    bus.iob_rvalid_i = 1'b0; bus.iob_rdata_i = '0; bus.iob_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'hCAFE_0040;

    // Reset state
    #12;
    check_eq("rst_awready", 64'(bus.axi_awready_o), 64'd0);
    check_eq("rst_iob_valid", 64'(bus.iob_valid_o), 64'd0);
    check_eq("rst_iob_addr", 64'(bus.iob_addr_o), 64'd0);
    check_eq("rst_bvalid", 64'(bus.axi_bvalid_o), 64'd0);
    check_eq("rst_rvalid", 64'(bus.axi_rvalid_o), 64'd0);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;

    // INCR write, len 3, 0x100, data 0x20..0x23
    b0 = n_acc;
    write_burst(1'b1, 24'h100, 8'd3, 2'b01, 3'd2, 32'h20, 0, 2'b00);
    check_eq("wr_acc_cnt", 64'(n_acc - b0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("wr_iob_addr", 64'(log_addr[b0+i]), 64'(32'h100 + 32'(4*i)));
      check_eq("wr_iob_data", 64'(log_data[b0+i]), 64'(32'h20 + 32'(i)));
      check_eq("wr_iob_is_wr", 64'(log_wr[b0+i]), 64'd1);
    end

    // INCR read back
    b0 = n_acc;
    read_burst(1'b1, 24'h100, 8'd3, 2'b01, 3'd2, 32'h20, 32'd1, 2'b00, 0);
    check_eq("rd_acc_cnt", 64'(n_acc - b0), 64'd4);

    // FIXED read, len 2, 0x40
    b0 = n_acc;
    read_burst(1'b0, 24'h40, 8'd2, 2'b00, 3'd2, 32'hCAFE_0040, 32'd0, 2'b00, 0);
    check_eq("fx_acc_cnt", 64'(n_acc - b0), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq("fx_iob_addr", 64'(log_addr[b0+i]), 64'h40);
      check_eq("fx_iob_is_rd", 64'(log_wr[b0+i]), 64'd0);
    end

    // Backpressure: IOb ready delayed 5 cycles, rready toggling
    ready_delay = 5;
    b0 = n_acc;
    write_burst(1'b0, 24'h200, 8'd1, 2'b01, 3'd2, 32'h50, 0, 2'b00);
    check_eq("bp_wr_acc", 64'(n_acc - b0), 64'd2);
    check_eq("bp_wr_addr1", 64'(log_addr[b0+1]), 64'h204);
    b0 = n_acc;
    read_burst(1'b1, 24'h200, 8'd1, 2'b01, 3'd2, 32'h50, 32'd1, 2'b00, 1);
    read_burst(1'b0, 24'h100, 8'd3, 2'b01, 3'd2, 32'h20, 32'd1, 2'b00, 1);
    check_eq("bp_rd_acc", 64'(n_acc - b0), 64'd6);
    ready_delay = 0;

    // Simultaneous AW and AR, twice: expect W, R, W, R
    b0 = hs_n;
    for (int r = 0; r < 2; r++) begin
      fork
        write_burst(1'b0, 24'h300 + 24'(4*r), 8'd0, 2'b01, 3'd2, 32'h70 + 32'(r), 0, 2'b00);
        read_burst(1'b1, 24'h100, 8'd0, 2'b01, 3'd2, 32'h20, 32'd1, 2'b00, 0);
      join
    end
    check_eq("arb_0", 64'(hs_log[b0+0]), 64'd1);
    check_eq("arb_1", 64'(hs_log[b0+1]), 64'd2);
    check_eq("arb_2", 64'(hs_log[b0+2]), 64'd1);
    check_eq("arb_3", 64'(hs_log[b0+3]), 64'd2);

    // WRAP write, len 1: beats consumed, no IOb traffic, SLVERR
    b0 = n_acc; v0 = vcycles;
    write_burst(1'b1, 24'h80, 8'd1, 2'b10, 3'd2, 32'h90, 0, 2'b10);
    check_eq("wrap_acc", 64'(n_acc - b0), 64'd0);
    check_eq("wrap_valid_cyc", 64'(vcycles - v0), 64'd0);

    // Oversize read (size 3 on 32-bit bus), len 1: zero data, SLVERR
    v0 = vcycles;
    read_burst(1'b0, 24'h100, 8'd1, 2'b01, 3'd3, 32'h0, 32'd0, 2'b10, 0);
    check_eq("size_err_valid_cyc", 64'(vcycles - v0), 64'd0);

    // wlast on the wrong beat: both beats still written, B is SLVERR
    b0 = n_acc;
    write_burst(1'b1, 24'h280, 8'd1, 2'b01, 3'd2, 32'hA0, 1, 2'b10);
    check_eq("wlast_acc", 64'(n_acc - b0), 64'd2);
    check_eq("wlast_mem1", 64'(mem[8'hA1]), 64'hA1);

    // Reset while waiting for IOb read data
    hold_rvalid = 1;
    b0 = n_acc;
    ar_send(1'b1, 24'h100, 8'd0, 2'b01, 3'd2);
    t = 0;
    while (n_acc == b0 && t < TMO) begin @(negedge clk); t++; end
    check_eq("rw_accepted", 64'(n_acc - b0), 64'd1);
    @(posedge clk); #2;
    arst_n = 1'b0;
    #1;
    check_eq("rw_iob_valid", 64'(bus.iob_valid_o), 64'd0);
    check_eq("rw_iob_addr",  64'(bus.iob_addr_o),  64'd0);
    check_eq("rw_rvalid",    64'(bus.axi_rvalid_o), 64'd0);
    check_eq("rw_rid",       64'(bus.axi_rid_o),    64'd0);
    check_eq("rw_bvalid",    64'(bus.axi_bvalid_o), 64'd0);
    hold_rvalid = 0;
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    read_burst(1'b0, 24'h104, 8'd0, 2'b01, 3'd2, 32'h21, 32'd0, 2'b00, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
